dac_update_scheduler: RTL and testbench
=======================================

Name: dac_update_scheduler

Overview:
Shares the single serial DAC controller between N_CHAN PID output channels plus a reference-set request. Each channel deposits its latest output word into a coalescing shadow register. The scheduler issues one update at a time to the DAC controller in round-robin order and waits for that controller's done pulse before issuing the next. It sits between the per-channel PID output stage and the DAC controller. A watchdog recovers the scheduler if a done pulse never arrives.

Parameters:
W_DATA, 16, width of DAC data word
W_CHS, 3, width of channel index; N_CHAN == 2**W_CHS
N_CHAN, 8, number of requesting channels
TIMEOUT, 64, max cycles in ST_WAIT before abort (>= 40; a full DAC transfer takes 36 cycles)

Ports:
clk_in  in  1  system clock
reset_in  in  1  asynchronous, active-high reset
ref_set_in  in  1  one-cycle request: issue DAC internal-reference-set instruction
wr_data_in  in  N_CHAN*W_DATA  per-channel data; channel i occupies bits [i*W_DATA +: W_DATA]
wr_valid_in  in  N_CHAN  per-channel write strobe
dac_done_in  in  1  done pulse from the DAC controller
data_out  out  W_DATA  word presented to the DAC controller
channel_out  out  W_CHS  channel presented to the DAC controller
data_valid_out  out  1  one-cycle issue pulse to the DAC controller
ref_set_out  out  1  one-cycle ref-set pulse to the DAC controller
busy_out  out  1  high in any state other than ST_IDLE
pend_out  out  N_CHAN  pending-update bitmap
timeout_err_out  out  1  sticky; set on watchdog abort

Behaviour:
- Reset (async, any state): all outputs 0, all shadow registers 0, pend 0, ref_pend 0, rr_ptr 0, watchdog counter 0, state ST_IDLE.
- Shadow write: on a clock with wr_valid_in[i]=1, shadow[i] <= slice i and pend[i] <= 1. Last write wins; multiple writes before service coalesce into one update.
- ref_set_in=1 sets sticky ref_pend. Repeated requests coalesce.
- States:
  - ST_IDLE -> ST_REF when ref_pend=1. Reference set has strict priority over channel updates.
  - ST_IDLE -> ST_ISSUE when ref_pend=0 and pend!=0.
  - ST_REF: ref_set_out=1 for this cycle only; clear ref_pend; -> ST_WAIT.
  - ST_ISSUE: data_valid_out=1 for this cycle only; -> ST_WAIT.
  - ST_WAIT: dac_done_in=1 -> ST_IDLE. Watchdog reaching TIMEOUT-1 -> ST_IDLE and set timeout_err_out. The aborted update is dropped; no retry.
- Grant: on the ST_IDLE->ST_ISSUE edge, select the first i with pend[i]=1, searching rr_ptr, rr_ptr+1, ... modulo N_CHAN.
  - Same edge: latch data_out <= shadow[i] and channel_out <= i, and clear pend[i].
  - If wr_valid_in[i] is high on that same edge: the write has priority. pend[i] stays 1 and shadow[i] takes the new value. The issued word is the previous shadow value.
  - rr_ptr <= i+1 (wraps N_CHAN-1 -> 0) on the grant edge.
- data_out and channel_out hold stable from the grant until the next grant. They are unchanged by ST_REF.
- Latency from an idle, empty scheduler:
  - write sampled at edge k;
  - grant at edge k+1;
  - data_valid_out high in the cycle after edge k+1;
  - ST_WAIT entered at edge k+2.
- Watchdog counter: cleared on entry to ST_WAIT, increments each ST_WAIT cycle, saturates.
- dac_done_in outside ST_WAIT is ignored.
- timeout_err_out clears only on reset.

Decomposition:
- Shared package: state encodings (ST_IDLE, ST_REF, ST_ISSUE, ST_WAIT as 2-bit localparams), W_DATA/W_CHS/N_CHAN defaults, TIMEOUT default.
- One sub-module: rr_arbiter. Pure combinational. Inputs pend and rr_ptr; outputs grant index and grant_valid. Easy to unit-test separately.

Test Plan:
1. After reset, wr_valid_in[3]=1 with data 16'h1234 for one cycle:
   - data_valid_out pulses exactly 2 cycles later with channel_out=3, data_out=16'h1234;
   - dac_done_in 36 cycles later returns busy_out to 0.
2. Write channels 0, 5 and 7 in the same cycle; answer each issue with dac_done_in after 5 cycles:
   - issue order is 0, 5, 7;
   - a second burst to 0 and 5 after rr_ptr=0 issues 0 then 5.
3. While in ST_WAIT, write channel 2 with 16'h0001, then 16'h0002, then 16'h0003:
   - exactly one later issue for channel 2, with data_out=16'h0003.
4. ref_set_in and wr_valid_in[1] asserted in the same cycle:
   - ref_set_out pulses first, data_valid_out is not asserted;
   - after dac_done_in, channel 1 is issued.
5. Write channel 4, never assert dac_done_in:
   - after TIMEOUT cycles in ST_WAIT, state returns to ST_IDLE;
   - timeout_err_out=1 and pend_out[4]=0;
   - a later write to channel 4 issues normally, with timeout_err_out still 1.
6. Further grant and reset cases:
   - Write to channel 6 on its own grant edge: the old value is issued and pend_out[6] stays 1.
   - reset_in asserted mid-ST_WAIT: all outputs read 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/dac_update_scheduler_pkg.sv
// Shared defaults and FSM encoding for the DAC update scheduler.
package dac_update_scheduler_pkg;

  localparam int unsigned W_DATA_DEF  = 16;
  localparam int unsigned W_CHS_DEF   = 3;
  localparam int unsigned N_CHAN_DEF  = 1 << W_CHS_DEF;
  localparam int unsigned TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REF   = 2'd1,
    ST_ISSUE = 2'd2,
    ST_WAIT  = 2'd3
  } state_e;

endpackage

// File: rtl/dac_update_scheduler_if.sv
// Channel-write / DAC-controller bundle between the PID outputs, the scheduler and the DAC controller.
interface dac_update_scheduler_if
  import dac_update_scheduler_pkg::*;
#(
  parameter int unsigned W_DATA = W_DATA_DEF,
  parameter int unsigned W_CHS  = W_CHS_DEF,
  parameter int unsigned N_CHAN = N_CHAN_DEF
);

  logic                       ref_set_in;
  logic [N_CHAN*W_DATA-1:0]   wr_data_in;
  logic [N_CHAN-1:0]          wr_valid_in;
  logic                       dac_done_in;
  logic [W_DATA-1:0]          data_out;
  logic [W_CHS-1:0]           channel_out;
  logic                       data_valid_out;
  logic                       ref_set_out;
  logic                       busy_out;
  logic [N_CHAN-1:0]          pend_out;
  logic                       timeout_err_out;

  // Requesters and DAC controller side.
  modport master (
    output ref_set_in, wr_data_in, wr_valid_in, dac_done_in,
    input  data_out, channel_out, data_valid_out, ref_set_out,
           busy_out, pend_out, timeout_err_out
  );

  // Scheduler side.
  modport slave (
    input  ref_set_in, wr_data_in, wr_valid_in, dac_done_in,
    output data_out, channel_out, data_valid_out, ref_set_out,
           busy_out, pend_out, timeout_err_out
  );

endinterface

// File: rtl/dac_update_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first pending channel at or after rr_ptr, modulo N_CHAN.
module dac_update_scheduler_rr_arbiter
  import dac_update_scheduler_pkg::*;
#(
  parameter int unsigned W_CHS  = W_CHS_DEF,
  parameter int unsigned N_CHAN = N_CHAN_DEF
) (
  input  logic [N_CHAN-1:0] pend_i,
  input  logic [W_CHS-1:0]  rr_ptr_i,
  output logic [W_CHS-1:0]  gnt_idx_o,
  output logic              gnt_vld_o
);

  logic [W_CHS-1:0] idx;

  // Scan from the farthest offset down so the nearest pending channel wins.
  always_comb begin
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    idx       = '0;
    for (int k = N_CHAN - 1; k >= 0; k--) begin
      idx = rr_ptr_i + W_CHS'(k);
      if (pend_i[idx]) begin
        gnt_idx_o = idx;
        gnt_vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dac_update_scheduler.sv
// Shares one DAC controller between N_CHAN coalescing channel shadows and a reference-set request.
module dac_update_scheduler
  import dac_update_scheduler_pkg::*;
#(
  parameter int unsigned W_DATA  = W_DATA_DEF,
  parameter int unsigned W_CHS   = W_CHS_DEF,
  parameter int unsigned N_CHAN  = N_CHAN_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic                 clk_in,
  input  logic                 reset_in,
  dac_update_scheduler_if.slave bus
);

  localparam int unsigned W_WD = $clog2(TIMEOUT);
  localparam logic [W_WD-1:0] WD_LAST = W_WD'(TIMEOUT - 1);

  state_e                         state_q, state_d;
  logic [N_CHAN-1:0][W_DATA-1:0]  shadow_q, shadow_d;
  logic [N_CHAN-1:0]              pend_q, pend_d;
  logic                           ref_pend_q, ref_pend_d;
  logic [W_CHS-1:0]               rr_ptr_q, rr_ptr_d;
  logic [W_WD-1:0]                wd_q, wd_d;
  logic [W_DATA-1:0]              data_q, data_d;
  logic [W_CHS-1:0]               chan_q, chan_d;
  logic                           dv_q, dv_d;
  logic                           rs_q, rs_d;
  logic                           busy_q, busy_d;
  logic                           err_q, err_d;

  logic [W_CHS-1:0]               gnt_idx;
  logic                           gnt_vld;

  dac_update_scheduler_rr_arbiter #(
    .W_CHS  (W_CHS),
    .N_CHAN (N_CHAN)
  ) u_arb (
    .pend_i    (pend_q),
    .rr_ptr_i  (rr_ptr_q),
    .gnt_idx_o (gnt_idx),
    .gnt_vld_o (gnt_vld)
  );

  // Next-state, grant and shadow/pending bookkeeping.
  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    pend_d     = pend_q;
    ref_pend_d = ref_pend_q;
    rr_ptr_d   = rr_ptr_q;
    wd_d       = wd_q;
    data_d     = data_q;
    chan_d     = chan_q;
    err_d      = err_q;
    dv_d       = 1'b0;
    rs_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ref_pend_q) begin
          state_d = ST_REF;
          rs_d    = 1'b1;
        end else if (gnt_vld) begin
          state_d          = ST_ISSUE;
          dv_d             = 1'b1;
          data_d           = shadow_q[gnt_idx];
          chan_d           = gnt_idx;
          pend_d[gnt_idx]  = 1'b0;
          rr_ptr_d         = gnt_idx + W_CHS'(1);
        end
      end
      ST_REF: begin
        ref_pend_d = 1'b0;
        wd_d       = '0;
        state_d    = ST_WAIT;
      end
      ST_ISSUE: begin
        wd_d    = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.dac_done_in) begin
          state_d = ST_IDLE;
        end else if (wd_q == WD_LAST) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q + W_WD'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A write on the grant edge overrides the clear: the new value stays pending.
    for (int i = 0; i < N_CHAN; i++) begin
      if (bus.wr_valid_in[i]) begin
        shadow_d[i] = bus.wr_data_in[i*W_DATA +: W_DATA];
        pend_d[i]   = 1'b1;
      end
    end
    if (bus.ref_set_in) ref_pend_d = 1'b1;

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q    <= ST_IDLE;
      shadow_q   <= '0;
      pend_q     <= '0;
      ref_pend_q <= 1'b0;
      rr_ptr_q   <= '0;
      wd_q       <= '0;
      data_q     <= '0;
      chan_q     <= '0;
      dv_q       <= 1'b0;
      rs_q       <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      pend_q     <= pend_d;
      ref_pend_q <= ref_pend_d;
      rr_ptr_q   <= rr_ptr_d;
      wd_q       <= wd_d;
      data_q     <= data_d;
      chan_q     <= chan_d;
      dv_q       <= dv_d;
      rs_q       <= rs_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign bus.data_out        = data_q;
  assign bus.channel_out     = chan_q;
  assign bus.data_valid_out  = dv_q;
  assign bus.ref_set_out     = rs_q;
  assign bus.busy_out        = busy_q;
  assign bus.pend_out        = pend_q;
  assign bus.timeout_err_out = err_q;

endmodule

// File: tb/tb_dac_update_scheduler.sv
// Directed bench for dac_update_scheduler: latency, round-robin, coalescing, ref priority, watchdog, reset.
module tb_dac_update_scheduler;
  import dac_update_scheduler_pkg::*;

  localparam int unsigned W_DATA  = 16;
  localparam int unsigned W_CHS   = 3;
  localparam int unsigned N_CHAN  = 8;
  localparam int unsigned TIMEOUT = 64;

  logic clk_in = 1'b0;
  logic reset_in;
  int   npass = 0;
  int   ntot  = 0;
  int   cnt;

  always #5 clk_in = ~clk_in;

  dac_update_scheduler_if #(.W_DATA(W_DATA), .W_CHS(W_CHS), .N_CHAN(N_CHAN)) bus ();

  dac_update_scheduler #(
    .W_DATA  (W_DATA),
    .W_CHS   (W_CHS),
    .N_CHAN  (N_CHAN),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .bus      (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic clr_in();
    bus.ref_set_in  = 1'b0;
    bus.wr_data_in  = '0;
    bus.wr_valid_in = '0;
    bus.dac_done_in = 1'b0;
  endtask

  task automatic do_reset();
    clr_in();
    reset_in = 1'b1;
    cyc();
    cyc();
    reset_in = 1'b0;
    cyc();
  endtask

  task automatic set_wr(input int ch, input logic [15:0] d);
    bus.wr_valid_in[ch] = 1'b1;
    bus.wr_data_in[ch*W_DATA +: W_DATA] = d;
  endtask

  task automatic done_pulse();
    bus.dac_done_in = 1'b1;
    cyc();
    bus.dac_done_in = 1'b0;
  endtask

  task automatic wait_dv(input string tag);
    int n = 0;
    while (bus.data_valid_out !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    chk({tag, "_dv_seen"}, 32'(bus.data_valid_out), 32'd1);
  endtask

  task automatic serve(input string tag, input int ch, input logic [15:0] d, input int nwait);
    wait_dv(tag);
    chk({tag, "_chan"}, 32'(bus.channel_out), 32'(ch));
    chk({tag, "_data"}, 32'(bus.data_out), 32'(d));
    cyc();
    chk({tag, "_dv_one_cycle"}, 32'(bus.data_valid_out), 32'd0);
    repeat (nwait - 1) cyc();
    done_pulse();
    chk({tag, "_idle_after_done"}, 32'(bus.busy_out), 32'd0);
  endtask

  initial begin
    clr_in();
    reset_in = 1'b1;
    #1;

    // 1: single write latency and a full-length transfer
    do_reset();
    chk("rst_data", 32'(bus.data_out), 32'd0);
    chk("rst_dv", 32'(bus.data_valid_out), 32'd0);
    chk("rst_busy", 32'(bus.busy_out), 32'd0);
    chk("rst_pend", 32'(bus.pend_out), 32'd0);
    chk("rst_err", 32'(bus.timeout_err_out), 32'd0);
    set_wr(3, 16'h1234);
    cyc();
    clr_in();
    chk("t1_dv_early", 32'(bus.data_valid_out), 32'd0);
    chk("t1_pend", 32'(bus.pend_out), 32'h08);
    cyc();
    chk("t1_dv", 32'(bus.data_valid_out), 32'd1);
    chk("t1_chan", 32'(bus.channel_out), 32'd3);
    chk("t1_data", 32'(bus.data_out), 32'h1234);
    chk("t1_pend_clr", 32'(bus.pend_out), 32'd0);
    cyc();
    chk("t1_dv_drop", 32'(bus.data_valid_out), 32'd0);
    repeat (35) cyc();
    chk("t1_busy_wait", 32'(bus.busy_out), 32'd1);
    done_pulse();
    chk("t1_busy_done", 32'(bus.busy_out), 32'd0);

    // 2: round-robin order including pointer wrap
    do_reset();
    set_wr(0, 16'h0A00);
    set_wr(5, 16'h0A05);
    set_wr(7, 16'h0A07);
    cyc();
    clr_in();
    serve("t2a", 0, 16'h0A00, 5);
    serve("t2b", 5, 16'h0A05, 5);
    serve("t2c", 7, 16'h0A07, 5);
    set_wr(0, 16'hB000);
    set_wr(5, 16'hB005);
    cyc();
    clr_in();
    serve("t2d", 0, 16'hB000, 5);
    serve("t2e", 5, 16'hB005, 5);

    // 3: coalescing of repeated writes while busy
    do_reset();
    set_wr(0, 16'hC000);
    cyc();
    clr_in();
    wait_dv("t3_first");
    cyc();
    set_wr(2, 16'h0001);
    cyc();
    set_wr(2, 16'h0002);
    cyc();
    set_wr(2, 16'h0003);
    cyc();
    clr_in();
    chk("t3_pend", 32'(bus.pend_out), 32'h04);
    chk("t3_busy", 32'(bus.busy_out), 32'd1);
    done_pulse();
    serve("t3", 2, 16'h0003, 5);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (bus.data_valid_out === 1'b1) cnt++;
    end
    chk("t3_no_extra_issue", 32'(cnt), 32'd0);
    chk("t3_pend_empty", 32'(bus.pend_out), 32'd0);

    // 4: reference set beats a simultaneous channel write
    do_reset();
    bus.ref_set_in = 1'b1;
    set_wr(1, 16'h1111);
    cyc();
    clr_in();
    chk("t4_rs_early", 32'(bus.ref_set_out), 32'd0);
    chk("t4_pend", 32'(bus.pend_out), 32'h02);
    cyc();
    chk("t4_rs", 32'(bus.ref_set_out), 32'd1);
    chk("t4_no_dv", 32'(bus.data_valid_out), 32'd0);
    chk("t4_data_untouched", 32'(bus.data_out), 32'd0);
    cyc();
    chk("t4_rs_drop", 32'(bus.ref_set_out), 32'd0);
    chk("t4_no_dv2", 32'(bus.data_valid_out), 32'd0);
    repeat (3) cyc();
    done_pulse();
    chk("t4_idle", 32'(bus.busy_out), 32'd0);
    serve("t4", 1, 16'h1111, 5);

    // 5: watchdog abort, sticky error, later normal issue
    do_reset();
    set_wr(4, 16'h4444);
    cyc();
    clr_in();
    wait_dv("t5_first");
    repeat (TIMEOUT) cyc();
    chk("t5_still_wait", 32'(bus.busy_out), 32'd1);
    chk("t5_no_err_yet", 32'(bus.timeout_err_out), 32'd0);
    cyc();
    chk("t5_abort_idle", 32'(bus.busy_out), 32'd0);
    chk("t5_err", 32'(bus.timeout_err_out), 32'd1);
    chk("t5_pend4", 32'(bus.pend_out[4]), 32'd0);
    set_wr(4, 16'h5555);
    cyc();
    clr_in();
    serve("t5", 4, 16'h5555, 3);
    chk("t5_err_sticky", 32'(bus.timeout_err_out), 32'd1);

    // 6a: write on the channel's own grant edge
    do_reset();
    set_wr(6, 16'h6666);
    cyc();
    set_wr(6, 16'h7777);
    cyc();
    clr_in();
    chk("t6_dv", 32'(bus.data_valid_out), 32'd1);
    chk("t6_old_data", 32'(bus.data_out), 32'h6666);
    chk("t6_chan", 32'(bus.channel_out), 32'd6);
    chk("t6_pend_kept", 32'(bus.pend_out), 32'h40);
    repeat (4) cyc();
    done_pulse();
    serve("t6_new", 6, 16'h7777, 5);

    // 6b: asynchronous reset in the middle of a wait
    set_wr(1, 16'hABCD);
    set_wr(2, 16'h2222);
    cyc();
    clr_in();
    wait_dv("t6b_first");
    cyc();
    cyc();
    chk("t6b_busy_pre", 32'(bus.busy_out), 32'd1);
    #1;
    reset_in = 1'b1;
    #1;
    chk("t6b_data", 32'(bus.data_out), 32'd0);
    chk("t6b_chan", 32'(bus.channel_out), 32'd0);
    chk("t6b_dv", 32'(bus.data_valid_out), 32'd0);
    chk("t6b_rs", 32'(bus.ref_set_out), 32'd0);
    chk("t6b_busy", 32'(bus.busy_out), 32'd0);
    chk("t6b_pend", 32'(bus.pend_out), 32'd0);
    chk("t6b_err", 32'(bus.timeout_err_out), 32'd0);
    @(negedge clk_in);
    reset_in = 1'b0;
    cyc();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
